// File: rtl/ppu_line_scaler_if.sv
// PPU scanline input / RGB sample output bundle of ppu_line_scaler.
// master: PPU side plus output-stage consumer; slave: the scaler.
interface ppu_line_scaler_if;
   logic       ppu_line_start;
   logic       ppu_pixel_valid;
   logic [5:0] ppu_pixel_idx;
   logic       ppu_grayscale;
   logic [2:0] ppu_emphasis;
   logic [7:0] red_dout;
   logic [7:0] green_dout;
   logic [7:0] blue_dout;
   logic       line_ready;

   modport master (
      output ppu_line_start, ppu_pixel_valid, ppu_pixel_idx,
      output ppu_grayscale, ppu_emphasis,
      input  red_dout, green_dout, blue_dout, line_ready
   );

   modport slave (
      input  ppu_line_start, ppu_pixel_valid, ppu_pixel_idx,
      input  ppu_grayscale, ppu_emphasis,
      output red_dout, green_dout, blue_dout, line_ready
   );
endinterface

// File: rtl/ppu_line_scaler.sv
// NES PPU scanline to 640-slot RGB line scaler (ping-pong buffer, 2x).
// Ports: pclk, rst (sync, active-high), bus (slave): ppu_line_start,
//   ppu_pixel_valid, ppu_pixel_idx, ppu_grayscale, ppu_emphasis in;
//   red_dout, green_dout, blue_dout, line_ready out.
// Option: PPU_EMPHASIS_EN enables colour emphasis (one extra stage).
module ppu_line_scaler #(
   parameter int         H_BORDER   = 64,
   parameter int         SLOTS      = 800,
   parameter logic [5:0] BORDER_IDX = 6'h0F
) (
   input logic               pclk,
   input logic               rst,
   ppu_line_scaler_if.slave  bus
);
   localparam int PERIOD  = 2 * SLOTS;
   localparam int PIC_END = H_BORDER + 512;
`ifdef PPU_EMPHASIS_EN
   localparam int LOOK = 5;
`else
   localparam int LOOK = 4;
`endif
   localparam logic [10:0] LAST = 11'(PERIOD - 1);

   localparam logic [23:0] PAL [0:63] = '{
      24'h626262, 24'h001FB2, 24'h2404C8, 24'h5200B2,
      24'h730076, 24'h800024, 24'h730B00, 24'h522800,
      24'h244400, 24'h005700, 24'h005C00, 24'h005324,
      24'h003C76, 24'h000000, 24'h000000, 24'h000000,
      24'hABABAB, 24'h0D57FF, 24'h4B30FF, 24'h8A13FF,
      24'hBC08D6, 24'hD21269, 24'hC72E00, 24'h9D5400,
      24'h607B00, 24'h209800, 24'h00A300, 24'h009942,
      24'h007DB4, 24'h000000, 24'h000000, 24'h000000,
      24'hFFFFFF, 24'h53AEFF, 24'h9085FF, 24'hD365FF,
      24'hFF57FF, 24'hFF5DCF, 24'hFF7757, 24'hFA9E00,
      24'hBDC700, 24'h7AE700, 24'h43F611, 24'h26EF7E,
      24'h2CD5F6, 24'h4E4E4E, 24'h000000, 24'h000000,
      24'hFFFFFF, 24'hB6E1FF, 24'hCED1FF, 24'hE9C3FF,
      24'hFFBCFF, 24'hFFBDF4, 24'hFFC6C3, 24'hFFD59A,
      24'hE9E681, 24'hCEF481, 24'hB6FB9A, 24'hA9FAC3,
      24'hA9F0F4, 24'hB8B8B8, 24'h000000, 24'h000000
   };

   logic [5:0]  mem [0:511];

   logic [10:0] x_cnt;
   logic [10:0] la_cnt;
   logic        wr_bank, wr_bank_n;
   logic [8:0]  wr_ptr, wr_ptr_n;
   logic [1:0]  done, done_n;
   logic        last_bank, last_bank_n;
   logic        rd_bank, rd_bank_n;
   logic        ready, ready_n;
   logic        we;
   logic [8:0]  waddr;

   logic [9:0]  la_slot;
   logic [9:0]  rel;
   logic        la_pic;
   logic        s1_pic;
   logic [8:0]  s1_addr;
   logic        s2_pic;
   logic [5:0]  s2_idx;
   logic [5:0]  idx_m;
   logic [23:0] s3_rgb;
   logic [23:0] fin_rgb;
   logic [23:0] rgb_q;
   logic        unused_ok;

   // Write side and read-bank selection, all from next-state values so
   // a line_start in the swap cycle is already honoured.
   always_comb begin
      wr_bank_n   = wr_bank;
      wr_ptr_n    = wr_ptr;
      done_n      = done;
      last_bank_n = last_bank;
      rd_bank_n   = rd_bank;
      ready_n     = ready;
      we          = 1'b0;
      waddr       = {wr_bank, wr_ptr[7:0]};
      if (bus.ppu_line_start) begin
         wr_bank_n        = ~wr_bank;
         done_n[~wr_bank] = 1'b0;
         wr_ptr_n         = '0;
      end
      if (bus.ppu_pixel_valid && !wr_ptr_n[8]) begin
         we       = 1'b1;
         waddr    = {wr_bank_n, wr_ptr_n[7:0]};
         wr_ptr_n = wr_ptr_n + 9'd1;
         if (wr_ptr_n[8]) begin
            done_n[wr_bank_n] = 1'b1;
            last_bank_n       = wr_bank_n;
         end
      end
      if (x_cnt == LAST) begin
         if (done_n[last_bank_n]) begin
            rd_bank_n = last_bank_n;
            ready_n   = 1'b1;
         end else if (done_n[~last_bank_n]) begin
            rd_bank_n = ~last_bank_n;
            ready_n   = 1'b1;
         end else begin
            ready_n   = 1'b0;
         end
      end
      // A bank being rewritten is never shown.
      if (rd_bank_n == wr_bank_n && !done_n[rd_bank_n])
         ready_n = 1'b0;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         x_cnt     <= '0;
         la_cnt    <= 11'(LOOK);
         wr_bank   <= 1'b0;
         wr_ptr    <= '0;
         done      <= '0;
         last_bank <= 1'b0;
         rd_bank   <= 1'b0;
         ready     <= 1'b0;
      end else begin
         x_cnt     <= (x_cnt == LAST) ? '0 : x_cnt + 11'd1;
         la_cnt    <= (la_cnt == LAST) ? '0 : la_cnt + 11'd1;
         wr_bank   <= wr_bank_n;
         wr_ptr    <= wr_ptr_n;
         done      <= done_n;
         last_bank <= last_bank_n;
         rd_bank   <= rd_bank_n;
         ready     <= ready_n;
      end
   end

   always_ff @(posedge pclk) begin
      if (we)
         mem[waddr] <= bus.ppu_pixel_idx;
   end

   // la_cnt runs LOOK cycles ahead so the last stage lands on slot edges.
   assign la_slot = la_cnt[10:1];
   assign rel     = la_slot - 10'(H_BORDER);
   assign la_pic  = (la_slot >= 10'(H_BORDER)) &&
                    (la_slot < 10'(PIC_END));

   always_comb begin
      idx_m = BORDER_IDX;
      if (s2_pic)
         idx_m = bus.ppu_grayscale ? (s2_idx & 6'h30) : s2_idx;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         s1_pic  <= 1'b0;
         s1_addr <= '0;
         s2_pic  <= 1'b0;
         s2_idx  <= '0;
         s3_rgb  <= '0;
      end else begin
         s1_pic  <= la_pic && ready;
         s1_addr <= {rd_bank, rel[8:1]};
         s2_pic  <= s1_pic;
         s2_idx  <= mem[s1_addr];
         s3_rgb  <= PAL[idx_m];
      end
   end

`ifdef PPU_EMPHASIS_EN
   logic [2:0]  s3_emph;
   logic [23:0] s4_rgb;

   function automatic logic [7:0] att(input logic [7:0] c);
      return (c >> 1) + (c >> 2);
   endfunction

   always_ff @(posedge pclk) begin
      if (rst) begin
         s3_emph <= '0;
         s4_rgb  <= '0;
      end else begin
         s3_emph <= bus.ppu_emphasis;
         // emphasis bits are {B,G,R}; clear bits dim their channel
         s4_rgb[23:16] <= (|s3_emph && !s3_emph[0]) ?
                          att(s3_rgb[23:16]) : s3_rgb[23:16];
         s4_rgb[15:8]  <= (|s3_emph && !s3_emph[1]) ?
                          att(s3_rgb[15:8]) : s3_rgb[15:8];
         s4_rgb[7:0]   <= (|s3_emph && !s3_emph[2]) ?
                          att(s3_rgb[7:0]) : s3_rgb[7:0];
      end
   end

   assign fin_rgb   = s4_rgb;
   assign unused_ok = ^{la_cnt[0], rel[9], rel[0]};
`else
   assign fin_rgb   = s3_rgb;
   assign unused_ok = ^{la_cnt[0], rel[9], rel[0], bus.ppu_emphasis};
`endif

   // Load only on edges entering an even x_cnt: one slot per two pclk.
   always_ff @(posedge pclk) begin
      if (rst)
         rgb_q <= '0;
      else if (x_cnt[0])
         rgb_q <= fin_rgb;
   end

   assign bus.red_dout   = rgb_q[23:16];
   assign bus.green_dout = rgb_q[15:8];
   assign bus.blue_dout  = rgb_q[7:0];
   assign bus.line_ready = ready;
endmodule

// File: tb/tb_ppu_line_scaler.sv
// Randomized bench for ppu_line_scaler with a line-level reference model.
// Model works per output period: which line is shown and its 2x mapping.
module tb_ppu_line_scaler;
   localparam int PERIOD = 1600;

   localparam logic [23:0] PAL [0:63] = '{
      24'h626262, 24'h001FB2, 24'h2404C8, 24'h5200B2,
      24'h730076, 24'h800024, 24'h730B00, 24'h522800,
      24'h244400, 24'h005700, 24'h005C00, 24'h005324,
      24'h003C76, 24'h000000, 24'h000000, 24'h000000,
      24'hABABAB, 24'h0D57FF, 24'h4B30FF, 24'h8A13FF,
      24'hBC08D6, 24'hD21269, 24'hC72E00, 24'h9D5400,
      24'h607B00, 24'h209800, 24'h00A300, 24'h009942,
      24'h007DB4, 24'h000000, 24'h000000, 24'h000000,
      24'hFFFFFF, 24'h53AEFF, 24'h9085FF, 24'hD365FF,
      24'hFF57FF, 24'hFF5DCF, 24'hFF7757, 24'hFA9E00,
      24'hBDC700, 24'h7AE700, 24'h43F611, 24'h26EF7E,
      24'h2CD5F6, 24'h4E4E4E, 24'h000000, 24'h000000,
      24'hFFFFFF, 24'hB6E1FF, 24'hCED1FF, 24'hE9C3FF,
      24'hFFBCFF, 24'hFFBDF4, 24'hFFC6C3, 24'hFFD59A,
      24'hE9E681, 24'hCEF481, 24'hB6FB9A, 24'hA9FAC3,
      24'hA9F0F4, 24'hB8B8B8, 24'h000000, 24'h000000
   };

   logic pclk = 1'b0;
   logic rst  = 1'b1;

   ppu_line_scaler_if bus ();

   ppu_line_scaler dut (
      .pclk (pclk),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 pclk = ~pclk;

   int errs = 0;
   int chks = 0;

   // reference model state
   int         mx;
   logic [5:0] bank [2][256];
   logic [5:0] disp [256];
   bit         comp [2];
   bit         wb, lastb, rd, rdy, skip;
   int         ptr;

   // inputs seen at the previous negedge = inputs of the edge in between
   bit         p_rst = 1'b1;
   logic       p_ls  = 1'b0;
   logic       p_v   = 1'b0;
   logic [5:0] p_idx = '0;

   task automatic check(input string nm, input logic [23:0] act,
                        input logic [23:0] exp);
      chks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s x=%0d actual=%h required=%h", nm, mx, act, exp);
      end
   endtask

   task automatic apply();
      bit wrap;
      if (p_rst) begin
         mx = 0; wb = 0; ptr = 0; lastb = 0;
         comp[0] = 0; comp[1] = 0;
         rd = 0; rdy = 0; skip = 0;
         return;
      end
      wrap = (mx == PERIOD - 1);
      mx = wrap ? 0 : mx + 1;
      if (p_ls) begin
         wb = !wb; comp[wb] = 0; ptr = 0;
      end
      if (p_v && ptr < 256) begin
         bank[wb][ptr] = p_idx;
         ptr++;
         if (ptr == 256) begin
            comp[wb] = 1; lastb = wb;
         end
      end
      if (wrap) begin
         if (comp[lastb]) begin
            rd = lastb; rdy = 1;
         end else if (comp[!lastb]) begin
            rd = !lastb; rdy = 1;
         end else begin
            rdy = 0;
         end
         if (rdy) disp = bank[rd];
         skip = 0;
      end
      if (rdy && wb == rd && !comp[rd]) begin
         rdy = 0;
         if (!wrap) skip = 1;
      end
   endtask

   function automatic logic [7:0] dim(input logic [7:0] c);
      return 8'((int'(c) / 2) + (int'(c) / 4));
   endfunction

   function automatic logic [23:0] exp_rgb(input int x);
      int p;
      logic [5:0] i;
      logic [23:0] c;
      logic [2:0] e;
      p = x / 2;
      if (rdy && p >= 64 && p < 576) begin
         i = disp[(p - 64) / 2];
         if (bus.ppu_grayscale) i = i & 6'h30;
         c = PAL[i];
      end else begin
         c = PAL[6'h0F];
      end
      e = bus.ppu_emphasis;
`ifdef PPU_EMPHASIS_EN
      if (e != 0) begin
         if (!e[0]) c[23:16] = dim(c[23:16]);
         if (!e[1]) c[15:8]  = dim(c[15:8]);
         if (!e[2]) c[7:0]   = dim(c[7:0]);
      end
`endif
      return c;
   endfunction

   function automatic logic [23:0] rgb_now();
      return {bus.red_dout, bus.green_dout, bus.blue_dout};
   endfunction

   // per-cycle compare process
   initial begin
      forever begin
         @(negedge pclk);
         apply();
         check("line_ready", 24'(bus.line_ready), 24'(rdy));
         if (!skip) check("rgb", rgb_now(), exp_rgb(mx));
         p_rst = rst;
         p_ls  = bus.ppu_line_start;
         p_v   = bus.ppu_pixel_valid;
         p_idx = bus.ppu_pixel_idx;
      end
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic wait_x(input int t);
      int n;
      n = 0;
      do begin
         @(negedge pclk);
         #1;
         n++;
      end while (mx != t && n < 2 * PERIOD + 10);
      if (mx != t) begin
         chks++;
         errs++;
         $display("FAIL wait_x actual=%0d required=%0d", mx, t);
      end
   endtask

   function automatic logic [5:0] pix(input int mode, input logic [5:0] v,
                                      input int k);
      if (mode == 1) return v;
      if (mode == 2) return (k % 2 == 0) ? 6'h20 : 6'h0F;
      return 6'($urandom_range(63));
   endfunction

   task automatic send_line(input int n, input int mode,
                            input logic [5:0] v, input int gap);
      int k;
      k = 0;
      tick();
      bus.ppu_line_start  = 1'b1;
      bus.ppu_pixel_valid = 1'b0;
      if (gap > 0 && n > 0 && $urandom_range(1) == 1) begin
         bus.ppu_pixel_valid = 1'b1;
         bus.ppu_pixel_idx   = pix(mode, v, 0);
         k = 1;
      end
      tick();
      bus.ppu_line_start = 1'b0;
      while (k < n) begin
         if (int'($urandom_range(99)) < gap) begin
            bus.ppu_pixel_valid = 1'b0;
         end else begin
            bus.ppu_pixel_valid = 1'b1;
            bus.ppu_pixel_idx   = pix(mode, v, k);
            k++;
         end
         tick();
      end
      bus.ppu_pixel_valid = 1'b0;
   endtask

   task automatic lit(input string nm, input int x, input logic [23:0] e);
      wait_x(x);
      check(nm, rgb_now(), e);
   endtask

   initial begin
      bus.ppu_line_start  = 1'b0;
      bus.ppu_pixel_valid = 1'b0;
      bus.ppu_pixel_idx   = '0;
      bus.ppu_grayscale   = 1'b0;
      bus.ppu_emphasis    = '0;
      repeat (4) tick();
      rst = 1'b0;

      // idle after reset: black, not ready, for three periods
      repeat (3 * PERIOD) tick();
      check("idle_ready", 24'(bus.line_ready), 24'h0);
      check("idle_rgb", rgb_now(), 24'h000000);

      // flat white line, centred
      send_line(256, 1, 6'h30, 0);
      wait_x(PERIOD - 1);
      lit("white_s63", 126, 24'h000000);
      lit("white_s64", 128, 24'hFFFFFF);
      check("white_ready", 24'(bus.line_ready), 24'h1);
      lit("white_s575", 1151, 24'hFFFFFF);
      lit("white_s576", 1152, 24'h000000);

      // alternating line: each pixel spans two slots
      send_line(256, 2, 6'h00, 0);
      wait_x(PERIOD - 1);
      lit("alt_s65", 131, 24'hFFFFFF);
      lit("alt_s66", 132, 24'h000000);
      lit("alt_s68", 136, 24'hFFFFFF);

      // partial line is never shown; previous line stays
      send_line(100, 0, 6'h00, 10);
      wait_x(PERIOD - 1);
      wait_x(PERIOD - 1);
      lit("part_keep", 130, 24'hFFFFFF);
      check("part_ready", 24'(bus.line_ready), 24'h1);
      // next line_start reuses the shown bank: it must be hidden
      send_line(0, 0, 6'h00, 0);
      tick();
      check("hide_ready", 24'(bus.line_ready), 24'h0);

      // grayscale, changed only inside the right border
      wait_x(1300);
      tick();
      bus.ppu_grayscale = 1'b1;
      send_line(256, 1, 6'h2D, 0);
      wait_x(PERIOD - 1);
      lit("gray_2d", 400, 24'hFFFFFF);
      wait_x(1300);
      tick();
      bus.ppu_grayscale = 1'b0;

      // emphasis on red
      wait_x(1300);
      tick();
      bus.ppu_emphasis = 3'b001;
      send_line(256, 1, 6'h30, 0);
      wait_x(PERIOD - 1);
`ifdef PPU_EMPHASIS_EN
      lit("emph_r", 400, 24'hFFBEBE);
`else
      lit("emph_r", 400, 24'hFFFFFF);
`endif
      wait_x(1300);
      tick();
      bus.ppu_emphasis = 3'b000;

      // randomized lines
      for (int l = 0; l < 24; l++) begin
         int n, r;
         if ($urandom_range(3) == 0) begin
            wait_x(1300 + int'($urandom_range(150)));
            tick();
            bus.ppu_grayscale = 1'($urandom_range(1));
            bus.ppu_emphasis  = 3'($urandom_range(7));
         end
         r = int'($urandom_range(9));
         if (r < 6)      n = 256;
         else if (r < 8) n = 256 + int'($urandom_range(20));
         else            n = 1 + int'($urandom_range(254));
         repeat ($urandom_range(400)) tick();
         send_line(n, 0, 6'h00, int'($urandom_range(60)));
      end
      wait_x(PERIOD - 1);
      wait_x(PERIOD - 1);

      // reset in the middle of a displayed line
      bus.ppu_grayscale = 1'b0;
      bus.ppu_emphasis  = 3'b000;
      send_line(256, 1, 6'h20, 0);
      wait_x(PERIOD - 1);
      wait_x(600);
      tick();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      wait_x(PERIOD - 1);
      lit("rst_rgb", 400, 24'h000000);
      check("rst_ready", 24'(bus.line_ready), 24'h0);
      send_line(256, 1, 6'h20, 0);
      wait_x(PERIOD - 1);
      lit("post_rst", 400, 24'hFFFFFF);
      wait_x(PERIOD - 1);

      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end
endmodule
